// File: rtl/tcp_pkt_queue.sv
// AXI4-Stream beat queue for TCP data/meta channels: circular buffer with
// first-word fall-through output and optional store-and-forward packet release.
module tcp_pkt_queue #(
    parameter int DATA_BITS = 512,
    parameter int DEPTH     = 64,
    parameter bit PKT_MODE  = 1'b1,
    parameter int AFULL_THR = DEPTH - 8,
    parameter int CNT_BITS  = $clog2(DEPTH) + 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [CNT_BITS-1:0]    count,
    output logic [CNT_BITS-1:0]    pkt_count,
    output logic                   almost_full
);

    localparam int AW        = $clog2(DEPTH);
    localparam int PTR_W     = AW + 1;
    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam int ENT_BITS  = DATA_BITS + KEEP_BITS + 1;

    logic [ENT_BITS-1:0] mem [DEPTH];
    logic [ENT_BITS-1:0] rd_entry;

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr_nxt;
    logic [PTR_W-1:0]    rd_ptr_nxt;
    logic [CNT_BITS-1:0] count_nxt;
    logic [CNT_BITS-1:0] pkt_count_nxt;

    logic ready_flag;
    logic draining;
    logic full;
    logic empty;
    logic release_ok;
    logic push;
    logic pop;
    logic push_last;
    logic pop_last;

    assign full  = (count == CNT_BITS'(DEPTH));
    assign empty = (count == '0);

    assign s_axis_tready = ready_flag && !full;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign push_last     = push && s_axis_tlast;

    // First-word fall-through: the head entry is always presented.
    assign rd_entry     = mem[rd_ptr[AW-1:0]];
    assign m_axis_tlast = rd_entry[ENT_BITS-1];
    assign m_axis_tkeep = rd_entry[DATA_BITS +: KEEP_BITS];
    assign m_axis_tdata = rd_entry[DATA_BITS-1:0];

    // Store-and-forward holds the head until a whole packet is stored; a full
    // queue with no complete packet falls back to cut-through to avoid deadlock.
    assign release_ok    = !PKT_MODE || (pkt_count != '0) || full || draining;
    assign m_axis_tvalid = !empty && release_ok;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign pop_last      = pop && m_axis_tlast;

    always_comb begin
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        pkt_count_nxt = pkt_count;
        if (push) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
        if (push_last && !pop_last) begin
            pkt_count_nxt = pkt_count + CNT_BITS'(1);
        end else if (pop_last && !push_last) begin
            pkt_count_nxt = pkt_count - CNT_BITS'(1);
        end
        // The extra pointer MSB makes the difference exact for 0..DEPTH.
        count_nxt = CNT_BITS'(wr_ptr_nxt - rd_ptr_nxt);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pkt_count   <= '0;
            ready_flag  <= 1'b0;
            draining    <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            ready_flag  <= 1'b1;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            pkt_count   <= pkt_count_nxt;
            almost_full <= (int'(count_nxt) >= AFULL_THR);
            if (pop_last) begin
                draining <= 1'b0;
            end else if (PKT_MODE && full && (pkt_count == '0)) begin
                draining <= 1'b1;
            end
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

endmodule

// File: tb/tb_tcp_pkt_queue.sv
// Bench for tcp_pkt_queue: one cut-through and one store-and-forward instance,
// a per-instance scoreboard, a state-vector table and corner-case sequences.
module tb_tcp_pkt_queue;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int NRAND = 10000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          s_tvalid [2];
    logic          s_tready [2];
    logic [DW-1:0] s_tdata  [2];
    logic [KW-1:0] s_tkeep  [2];
    logic          s_tlast  [2];
    logic          m_tvalid [2];
    logic          m_tready [2];
    logic [DW-1:0] m_tdata  [2];
    logic [KW-1:0] m_tkeep  [2];
    logic          m_tlast  [2];
    logic [CW-1:0] cnt      [2];
    logic [CW-1:0] pcnt     [2];
    logic          afull    [2];

    tcp_pkt_queue #(.DATA_BITS(DW), .DEPTH(DEPTH), .PKT_MODE(1'b0), .AFULL_THR(6)) u_ct (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]), .s_axis_tdata(s_tdata[0]),
        .s_axis_tkeep(s_tkeep[0]), .s_axis_tlast(s_tlast[0]),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]), .m_axis_tdata(m_tdata[0]),
        .m_axis_tkeep(m_tkeep[0]), .m_axis_tlast(m_tlast[0]),
        .count(cnt[0]), .pkt_count(pcnt[0]), .almost_full(afull[0])
    );

    tcp_pkt_queue #(.DATA_BITS(DW), .DEPTH(DEPTH), .PKT_MODE(1'b1), .AFULL_THR(6)) u_sf (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]), .s_axis_tdata(s_tdata[1]),
        .s_axis_tkeep(s_tkeep[1]), .s_axis_tlast(s_tlast[1]),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]), .m_axis_tdata(m_tdata[1]),
        .m_axis_tkeep(m_tkeep[1]), .m_axis_tlast(m_tlast[1]),
        .count(cnt[1]), .pkt_count(pcnt[1]), .almost_full(afull[1])
    );

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int   k;
        logic sv, sl, mr;
        int   cnt, pkt;
        logic mv, sr, af;
    } vec_t;

    beat_t   sb0[$];
    beat_t   sb1[$];
    vec_t    tbl[$];
    int      checks = 0;
    int      errors = 0;
    int      popped [2];
    int      maxcnt [2];
    int      fulls  [2];
    int      empties[2];
    int      sent   [2];
    int      rem    [2];
    logic    fired  [2];
    logic [DW-1:0] nxt [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: record accepted input beats, compare each popped beat in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb0.delete();
            sb1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                beat_t b;
                beat_t e;
                if (s_tvalid[k] && s_tready[k]) begin
                    b = {s_tlast[k], s_tkeep[k], s_tdata[k]};
                    if (k == 0) sb0.push_back(b);
                    else        sb1.push_back(b);
                end
                if (m_tvalid[k] && m_tready[k]) begin
                    b = {m_tlast[k], m_tkeep[k], m_tdata[k]};
                    popped[k]++;
                    if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb%0d_underflow: got beat %0h expected none", k, b);
                    end else begin
                        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                        check($sformatf("sb%0d_beat", k), 64'(b), 64'(e));
                    end
                end
                check($sformatf("cnt%0d_bound", k), 64'(cnt[k] <= CW'(DEPTH)), 64'd1);
                if (int'(cnt[k]) > maxcnt[k]) maxcnt[k] = int'(cnt[k]);
            end
        end
    end

    task automatic step(input int k, input logic sv, input logic sl, input logic mr);
        logic f;
        s_tvalid[k] = sv;
        s_tlast[k]  = sl;
        s_tdata[k]  = nxt[k];
        s_tkeep[k]  = ~nxt[k][KW-1:0];
        m_tready[k] = mr;
        @(negedge clk);
        f = sv && s_tready[k];
        @(posedge clk);
        #1;
        if (f) nxt[k] = nxt[k] + 1;
        s_tvalid[k] = 1'b0;
        s_tlast[k]  = 1'b0;
        m_tready[k] = 1'b0;
    endtask

    task automatic add(input int k, input logic sv, input logic sl, input logic mr,
                       input int c, input int p, input logic mv, input logic sr, input logic af);
        vec_t v;
        v = '{k, sv, sl, mr, c, p, mv, sr, af};
        tbl.push_back(v);
    endtask

    task automatic check_idle_outputs(input int k, input string tag);
        check({tag, "_s_tready"}, 64'(s_tready[k]), 64'd0);
        check({tag, "_m_tvalid"}, 64'(m_tvalid[k]), 64'd0);
        check({tag, "_afull"},    64'(afull[k]),    64'd0);
        check({tag, "_count"},    64'(cnt[k]),      64'd0);
        check({tag, "_pkt"},      64'(pcnt[k]),     64'd0);
    endtask

    initial begin
        int base;
        int cyc;
        bit ok;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0; s_tdata[k] = '0; s_tkeep[k] = '0;
            m_tready[k] = 1'b0; nxt[k] = DW'(k * 32'h1000);
            popped[k] = 0; maxcnt[k] = 0; fulls[k] = 0; empties[k] = 0;
            sent[k] = 0; rem[k] = 0; fired[k] = 1'b0;
        end

        // Reset state and first ready edge
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 64'(s_tready[0]), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge0", 64'(s_tready[0]), 64'd1);
        check("ready_after_edge1", 64'(s_tready[1]), 64'd1);

        // Cut-through: fill 8 with output stalled, then drain one beat per cycle
        add(0,1,0,0, 1,0,1,1,0); add(0,1,0,0, 2,0,1,1,0); add(0,1,0,0, 3,0,1,1,0);
        add(0,1,1,0, 4,1,1,1,0); add(0,1,0,0, 5,1,1,1,0); add(0,1,0,0, 6,1,1,1,1);
        add(0,1,0,0, 7,1,1,1,1); add(0,1,1,0, 8,2,1,0,1); add(0,1,0,0, 8,2,1,0,1);
        add(0,0,0,1, 7,2,1,1,1); add(0,0,0,1, 6,2,1,1,1); add(0,0,0,1, 5,2,1,1,0);
        add(0,0,0,1, 4,1,1,1,0); add(0,0,0,1, 3,1,1,1,0); add(0,0,0,1, 2,1,1,1,0);
        add(0,0,0,1, 1,1,1,1,0); add(0,0,0,1, 0,0,0,1,0);
        // Store-and-forward: 3-beat packet, then pop-last with push of a new partial packet
        add(1,1,0,1, 1,0,0,1,0); add(1,1,0,1, 2,0,0,1,0); add(1,1,1,1, 3,1,1,1,0);
        add(1,0,0,1, 2,1,1,1,0); add(1,0,0,1, 1,1,1,1,0); add(1,1,0,1, 1,0,0,1,0);
        add(1,1,1,1, 2,1,1,1,0); add(1,0,0,1, 1,1,1,1,0); add(1,0,0,1, 0,0,0,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            step(v.k, v.sv, v.sl, v.mr);
            check($sformatf("row%0d_count", i),    64'(cnt[v.k]),      64'(v.cnt));
            check($sformatf("row%0d_pkt", i),      64'(pcnt[v.k]),     64'(v.pkt));
            check($sformatf("row%0d_m_tvalid", i), 64'(m_tvalid[v.k]), 64'(v.mv));
            check($sformatf("row%0d_s_tready", i), 64'(s_tready[v.k]), 64'(v.sr));
            check($sformatf("row%0d_afull", i),    64'(afull[v.k]),    64'(v.af));
        end

        // Oversize packet: 12 beats through an 8-deep store-and-forward queue
        base = popped[1];
        maxcnt[1] = 0;
        sent[1] = 0;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            logic f;
            s_tvalid[1] = (sent[1] < 12);
            s_tlast[1]  = (sent[1] == 11);
            s_tdata[1]  = nxt[1];
            s_tkeep[1]  = ~nxt[1][KW-1:0];
            m_tready[1] = 1'b1;
            @(negedge clk);
            f = s_tvalid[1] && s_tready[1];
            @(posedge clk);
            #1;
            if (f) begin sent[1]++; nxt[1] = nxt[1] + 1; end
            ok = (sent[1] == 12) && (popped[1] - base == 12);
        end
        s_tvalid[1] = 1'b0; s_tlast[1] = 1'b0; m_tready[1] = 1'b0;
        check("oversize_done",   64'(ok),                 64'd1);
        check("oversize_popped", 64'(popped[1] - base),   64'd12);
        check("oversize_filled", 64'(maxcnt[1]),          64'(DEPTH));
        check("oversize_count",  64'(cnt[1]),             64'd0);
        check("oversize_pkt",    64'(pcnt[1]),            64'd0);

        // Steady push+pop at count=1 with tlast on every beat
        step(1, 1'b1, 1'b1, 1'b0);
        check("steady_pre_count", 64'(cnt[1]), 64'd1);
        for (int i = 0; i < 20; i++) begin
            step(1, 1'b1, 1'b1, 1'b1);
            check($sformatf("steady%0d_count", i), 64'(cnt[1]),  64'd1);
            check($sformatf("steady%0d_pkt", i),   64'(pcnt[1]), 64'd1);
        end
        step(1, 1'b0, 1'b0, 1'b1);
        check("steady_post_count", 64'(cnt[1]), 64'd0);

        // Reset in the middle of a partially stored packet
        step(1, 1'b1, 1'b0, 1'b0);
        step(1, 1'b1, 1'b0, 1'b0);
        check("midpkt_count", 64'(cnt[1]), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs(1, "midrst");
        check("midrst_ready0", 64'(s_tready[0]), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_held_ready", 64'(s_tready[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready_rise", 64'(s_tready[1]), 64'd1);
        check("midrst_no_stale",   64'(m_tvalid[1]), 64'd0);
        check("midrst_count",      64'(cnt[1]),      64'd0);
        base = popped[1];
        step(1, 1'b1, 1'b1, 1'b0);
        step(1, 1'b0, 1'b0, 1'b1);
        check("midrst_one_pop", 64'(popped[1] - base), 64'd1);
        check("midrst_drained", 64'(cnt[1]), 64'd0);

        // Random traffic on both instances: 1-5 beat packets, random keep
        for (int k = 0; k < 2; k++) begin
            sent[k] = 0; rem[k] = 0; fired[k] = 1'b0; fulls[k] = 0; empties[k] = 0;
        end
        base = popped[0];
        cyc = popped[1];
        ok = 1'b0;
        for (int c = 0; c < 60000 && !ok; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!s_tvalid[k] || fired[k]) begin
                    if (sent[k] >= NRAND && rem[k] == 0) begin
                        s_tvalid[k] = 1'b0;
                        s_tlast[k]  = 1'b0;
                    end else begin
                        if (rem[k] == 0) rem[k] = $urandom_range(1, 5);
                        s_tvalid[k] = ($urandom_range(0, 9) < 7);
                        s_tdata[k]  = $urandom;
                        s_tkeep[k]  = KW'($urandom);
                        s_tlast[k]  = (rem[k] == 1);
                    end
                end
                m_tready[k] = ($urandom_range(0, 9) < (((c / 500) % 2 == 0) ? 4 : 9));
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                fired[k] = s_tvalid[k] && s_tready[k];
                if (cnt[k] == CW'(DEPTH)) fulls[k]++;
                if (cnt[k] == '0 && sent[k] > 0) empties[k]++;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (fired[k]) begin sent[k]++; rem[k]--; end
            end
            ok = (sent[0] >= NRAND) && (rem[0] == 0) && (cnt[0] == '0) &&
                 (sent[1] >= NRAND) && (rem[1] == 0) && (cnt[1] == '0);
        end
        for (int k = 0; k < 2; k++) begin
            s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0; m_tready[k] = 1'b0;
        end
        check("rand_done",     64'(ok),                 64'd1);
        check("rand_popped0",  64'(popped[0] - base),   64'(sent[0]));
        check("rand_popped1",  64'(popped[1] - cyc),    64'(sent[1]));
        check("rand_full0",    64'(fulls[0] > 0),       64'd1);
        check("rand_full1",    64'(fulls[1] > 0),       64'd1);
        check("rand_empty0",   64'(empties[0] > 0),     64'd1);
        check("rand_empty1",   64'(empties[1] > 0),     64'd1);
        check("rand_pkt0",     64'(pcnt[0]),            64'd0);
        check("rand_pkt1",     64'(pcnt[1]),            64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
